// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, FSM state encoding, width helper, digit validity.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   BCD_DIGIT_W    bits per packed BCD digit
//   state_t        serial converter FSM states (IDLE, CONV)
//   min_bin_w()    smallest binary width able to hold 10**digits-1
//   is_bcd_digit() true when a 4-bit field is a legal decimal digit (0..9)
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // ceil(log2(10**digits)): the number of bits needed for 0 .. 10**digits-1.
  function automatic int min_bin_w(input int digits);
    longint unsigned p;
    int              w;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    w = 0;
    for (int b = 0; b < 40; b++) begin
      if ((longint'(1) << b) < p) begin
        w = b + 1;
      end
    end
    return w;
  endfunction

  function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a field >= 8 after the right shift has 3 removed.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   d  in  4  digit field of the shift register after the shift
//   q  out 4  corrected digit field
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // A digit >= 8 minus 3 is still >= 5, so the subtract never wraps.
  assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter using reverse double-dabble, one shift/correct step per clock.
// Latency: done pulses BIN_W cycles after an accepted start; an invalid operand reports in 1 cycle.
// Backpressure: none; start is ignored while busy (no queueing), accepted again in the done cycle.
//
// Ports:
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   start    in   1          conversion request, sampled only while idle
//   bcd_in   in   4*DIGITS   packed BCD operand, digit 0 in bits [3:0], sampled with start
//   busy     out  1          conversion in progress
//   done     out  1          one-cycle pulse, bin_out/err valid
//   bin_out  out  BIN_W      binary result, held until replaced
//   err      out  1          operand contained a digit > 9
module bcd_to_bin_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int S_W   = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // Parameter legality is settled at elaboration time.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $fatal(1, "bcd_to_bin_serial: DIGITS must be in 1..8");
  end
  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_bin_w
    $fatal(1, "bcd_to_bin_serial: BIN_W too small for DIGITS");
  end

  state_t             state_q, state_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [S_W-1:0]     s_shift;
  logic [S_W-1:0]     s_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               operand_ok;
  logic               last_iter;

  // Operand validity: every digit must be 0..9.
  always_comb begin
    operand_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W])) begin
        operand_ok = 1'b0;
      end
    end
  end

  // One iteration: shift the whole register right, then correct each BCD field.
  // The binary part below the BCD fields passes through untouched.
  assign s_shift = s_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (s_shift[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .q (s_adj  [BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end
  assign s_adj[BIN_W-1:0] = s_shift[BIN_W-1:0];

  // cnt counts completed iterations; the edge seen with cnt = BIN_W-1 performs the last one.
  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!operand_ok) begin
            // Reject without converting; report straight away.
            err_d  = 1'b1;
            bin_d  = '0;
            done_d = 1'b1;
          end else begin
            s_d     = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        s_d   = s_adj;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          // All BCD fields have drained to zero; the low part is the result.
          bin_d   = s_adj[BIN_W-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy    = (state_q == CONV);
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Self-checking bench for bcd_to_bin_serial (DIGITS=4, BIN_W=14).
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_to_bin_serial;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                done;
  logic [BIN_W-1:0]    bin_out;
  logic                err;

  always #5 clk = ~clk;

  bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Decimal meaning of the operand: weighted digit sum, invalid if any digit exceeds 9.
  function automatic void model(input logic [15:0] bcd, output int val, output bit bad);
    int w;
    int d;
    val = 0;
    bad = 1'b0;
    w   = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      val = val + d * w;
      w   = w * 10;
    end
    if (bad) val = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and watch a 20-cycle window. lat = clock edges after the
  // start edge before done is seen (0 = cycle right after the start edge).
  task automatic run_conv(input logic [15:0] bcd, output int lat, output int nbusy,
                          output int ndone, output int got_bin, output bit got_err);
    lat     = -1;
    nbusy   = 0;
    ndone   = 0;
    got_bin = -1;
    got_err = 1'b0;
    bcd_in  = bcd;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    bcd_in  = 16'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat     = i;
          got_bin = int'(bin_out);
          got_err = err;
        end
      end
      tick();
    end
  endtask

  task automatic check_conv(input string tag, input logic [15:0] bcd,
                            input int exp_bin, input bit exp_err);
    int lat, nbusy, ndone, got_bin;
    bit got_err;
    run_conv(bcd, lat, nbusy, ndone, got_bin, got_err);
    chk({tag, " bin_out"}, got_bin, exp_bin);
    chk({tag, " err"}, got_err, exp_err);
    chk({tag, " done latency"}, lat, exp_err ? 0 : BIN_W);
    chk({tag, " done pulses"}, ndone, 1);
    chk({tag, " busy cycles"}, nbusy, exp_err ? 0 : BIN_W);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          val;
    bit          bad;
    bit          found;
    int          gap;
    int          ndone;
    logic [15:0] r;

    vecs[0] = '{bcd: 16'h0000, exp_bin: 0,    exp_err: 1'b0};
    vecs[1] = '{bcd: 16'h9999, exp_bin: 9999, exp_err: 1'b0};
    vecs[2] = '{bcd: 16'h1234, exp_bin: 1234, exp_err: 1'b0};
    vecs[3] = '{bcd: 16'h12A4, exp_bin: 0,    exp_err: 1'b1};
    vecs[4] = '{bcd: 16'h0007, exp_bin: 7,    exp_err: 1'b0};
    vecs[5] = '{bcd: 16'h8000, exp_bin: 8000, exp_err: 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset bin_out", bin_out, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table: zero, full scale, typical, invalid followed by recovery.
    for (int i = 0; i < 6; i++) begin
      check_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err);
    end

    // Start while busy is ignored: only one done, carrying the first operand.
    bcd_in = 16'h0042;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    ndone  = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        start  = 1'b1;
        bcd_in = 16'h0999;
      end else begin
        start  = 1'b0;
      end
      if (done) ndone++;
      tick();
    end
    start = 1'b0;
    chk("busy-start done pulses", ndone, 1);
    chk("busy-start bin_out", bin_out, 42);

    // Back-to-back: second start issued in the done cycle of the first.
    bcd_in = 16'h0500;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (done) found = 1'b1;
      else tick();
    end
    chk("b2b first done seen", found, 1);
    chk("b2b first bin_out", bin_out, 500);
    bcd_in = 16'h0025;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    gap    = 1;
    found  = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (done) found = 1'b1;
      else begin
        tick();
        gap++;
      end
    end
    chk("b2b second done seen", found, 1);
    chk("b2b done spacing", gap, BIN_W + 1);
    chk("b2b second bin_out", bin_out, 25);
    tick();
    tick();

    // Reset mid-conversion, with a nonzero result held from before.
    check_conv("pre-reset", 16'h0007, 7, 1'b0);
    bcd_in = 16'h1234;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid-reset busy", busy, 0);
    chk("mid-reset done", done, 0);
    chk("mid-reset err", err, 0);
    chk("mid-reset bin_out", bin_out, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check_conv("post-reset", 16'h0015, 15, 1'b0);

    // Random operands against the decimal model; about one in five has a bad digit.
    for (int n = 0; n < 40; n++) begin
      r = '0;
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 19) == 0) r[4*d +: 4] = 4'($urandom_range(10, 15));
        else                            r[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      model(r, val, bad);
      check_conv($sformatf("rand%0d %h", n, r), r, val, bad);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
